// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory request/response
// channel and the fetch-to-decode handshake.
interface instr_fetch_unit_if #(
    parameter int DWIDTH = 32
);
    logic              redirect_valid;
    logic [DWIDTH-1:0] redirect_pc;
    logic              imem_req;
    logic [DWIDTH-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DWIDTH-1:0] imem_rdata;
    logic              if_valid;
    logic [DWIDTH-1:0] if_instr;
    logic [DWIDTH-1:0] if_pc;
    logic              id_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a
// 2-entry {pc,instr} buffer towards decode, with branch redirect and flush.
module instr_fetch_unit #(
    parameter int                DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus,
    output logic [1:0]          dbg_state
);
    // Handshakes: a memory request transfers on a cycle with imem_req && imem_gnt;
    // decode consumes the head entry on a cycle with if_valid && id_ready.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [DWIDTH-1:0] PC_STEP    = DWIDTH'(4);
    localparam logic [DWIDTH-1:0] ALIGN_MASK = ~DWIDTH'(3);

    state_t            state, state_nx;
    logic [DWIDTH-1:0] fetch_pc, fetch_pc_nx;
    logic [DWIDTH-1:0] req_pc;
    logic              drop, drop_nx;
    logic [DWIDTH-1:0] fifo_pc    [2];
    logic [DWIDTH-1:0] fifo_instr [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count, count_nx;
    logic              granted, resp, push, pop, flush;

    assign granted = (state == S_REQ) && bus.imem_gnt;
    assign resp    = (state == S_WAIT) && bus.imem_rvalid;
    assign flush   = bus.redirect_valid;
    assign pop     = bus.if_valid && bus.id_ready;
    // A response racing a redirect belongs to the old path and is discarded.
    assign push    = resp && !drop && !flush;

    assign bus.imem_req  = rst_n && (state == S_REQ);
    assign bus.imem_addr = {fetch_pc[DWIDTH-1:2], 2'b00};
    assign bus.if_valid  = (count != 2'd0);
    assign bus.if_instr  = fifo_instr[rd_ptr];
    assign bus.if_pc     = fifo_pc[rd_ptr];
    assign dbg_state     = state;

    always_comb begin
        count_nx = count;
        if (flush) begin
            count_nx = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_nx = count + 2'd1;
                2'b01:   count_nx = count - 2'd1;
                default: count_nx = count;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        drop_nx     = drop;
        case (state)
            S_REQ: begin
                if (bus.imem_gnt) begin
                    fetch_pc_nx = fetch_pc + PC_STEP;
                    state_nx    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    drop_nx  = 1'b0;
                    state_nx = (count_nx < 2'd2) ? S_REQ : S_STALL;
                end
            end
            S_STALL: begin
                if ((count < 2'd2) || flush) state_nx = S_REQ;
            end
            default: state_nx = S_REQ;
        endcase
        // The drop flag only tracks a request whose response is still to come.
        if (flush) begin
            fetch_pc_nx = bus.redirect_pc & ALIGN_MASK;
            if (granted || ((state == S_WAIT) && !bus.imem_rvalid)) drop_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC & ALIGN_MASK;
            req_pc   <= '0;
            drop     <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            drop     <= drop_nx;
            count    <= count_nx;
            if (granted) req_pc <= fetch_pc;
            if (flush) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]    <= req_pc;
                    fifo_instr[wr_ptr] <= bus.imem_rdata;
                    wr_ptr             <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/decode/redirect traffic checked
// against an in-order queue of expected fetch PCs, plus directed corner steps.
module tb_instr_fetch_unit;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  ST_REQ   = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_STALL = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    instr_fetch_unit_if #(.DWIDTH(DW)) bus ();

    instr_fetch_unit #(.DWIDTH(DW), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          p_gnt, p_ready, p_redir, max_lat;
    bit          dir_redir;
    logic [31:0] dir_tgt;
    bit          mode_fullpop, chk_after_fullpop;
    bit          hold_chk;
    logic [31:0] hold_pc, hold_instr;
    int          n_pops;
    bit          cap_pop_en, cap_gnt_en;
    logic [31:0] cap_pop_pc, cap_gnt_addr;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe outputs at the negedge, then drive inputs for the next posedge.
    task automatic tick();
        bit          redir;
        bit          had_pend;
        logic [31:0] tgt;
        logic [31:0] e;
        @(negedge clk);
        if (chk_after_fullpop) begin
            chk("fullpop_state", 32'(dbg_state), 32'(ST_REQ));
            chk("fullpop_req", 32'(bus.imem_req), 32'd1);
            chk("fullpop_valid", 32'(bus.if_valid), 32'd1);
            chk_after_fullpop = 1'b0;
        end
        if (hold_chk) begin
            chk("hold_valid", 32'(bus.if_valid), 32'd1);
            chk("hold_pc", bus.if_pc, hold_pc);
            chk("hold_instr", bus.if_instr, hold_instr);
        end
        had_pend         = pend;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = $urandom;
        if (pend) begin
            if (pend_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_addr);
                pend            = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        bus.imem_gnt = 1'b0;
        if (bus.imem_req) begin
            chk("single_outstanding", 32'(had_pend), 32'd0);
            bus.imem_gnt = (int'($urandom_range(99)) < p_gnt);
        end
        if (mode_fullpop) begin
            bus.id_ready = bus.imem_rvalid && bus.if_valid && (dbg_state == ST_WAIT);
            if (bus.id_ready) begin
                chk_after_fullpop = 1'b1;
                mode_fullpop      = 1'b0;
            end
        end else begin
            bus.id_ready = (int'($urandom_range(99)) < p_ready);
        end
        redir     = dir_redir || (int'($urandom_range(99)) < p_redir);
        tgt       = dir_redir ? dir_tgt : $urandom;
        dir_redir = 1'b0;
        if (bus.if_valid && bus.id_ready) begin
            n_pops++;
            chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("if_pc", bus.if_pc, e);
                chk("if_instr", bus.if_instr, mem_word(e));
            end
            if (cap_pop_en) begin
                cap_pop_pc = bus.if_pc;
                cap_pop_en = 1'b0;
            end
        end
        if (bus.imem_req && bus.imem_gnt) begin
            chk("fetch_addr", bus.imem_addr, exp_fetch);
            if (cap_gnt_en) begin
                cap_gnt_addr = bus.imem_addr;
                cap_gnt_en   = 1'b0;
            end
            pend      = 1'b1;
            pend_addr = bus.imem_addr;
            pend_wait = int'($urandom_range(max_lat - 1, 0));
            if (!redir) exp_q.push_back(bus.imem_addr);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            exp_fetch = tgt & 32'hFFFF_FFFC;
        end
        hold_chk           = bus.if_valid && !bus.id_ready && !redir;
        hold_pc            = bus.if_pc;
        hold_instr         = bus.if_instr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
    endtask

    task automatic do_reset(bit stray);
        @(negedge clk);
        rst_n              = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_state", 32'(dbg_state), 32'(ST_REQ));
        rst_n = 1'b1;
        if (stray) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        exp_q.delete();
        pend              = 1'b0;
        exp_fetch         = RESET_PC;
        hold_chk          = 1'b0;
        mode_fullpop      = 1'b0;
        chk_after_fullpop = 1'b0;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk("post_rst_req", 32'(bus.imem_req), 32'd1);
        chk("post_rst_valid", 32'(bus.if_valid), 32'd0);
    endtask

    initial begin
        int n0;
        p_gnt = 100; p_ready = 100; p_redir = 0; max_lat = 1;
        dir_redir = 1'b0; dir_tgt = '0; n_pops = 0;
        cap_pop_en = 1'b0; cap_gnt_en = 1'b0;
        cap_pop_pc = '0; cap_gnt_addr = '0;
        do_reset(1'b0);

        // Streaming with a one-cycle memory and decode always ready.
        cap_pop_en = 1'b1;
        repeat (16) tick();
        chk("first_if_pc", cap_pop_pc, RESET_PC);

        // Decode stalls: buffer fills to two entries and requests stop.
        p_ready = 0;
        repeat (10) tick();
        chk("stall_state", 32'(dbg_state), 32'(ST_STALL));
        chk("stall_req", 32'(bus.imem_req), 32'd0);
        chk("stall_valid", 32'(bus.if_valid), 32'd1);
        chk("stall_buffered", 32'(exp_q.size()), 32'd2);
        p_ready = 100;
        n0 = n_pops;
        repeat (2) tick();
        chk("stall_drain_pops", 32'(n_pops - n0), 32'd2);

        // Pop coinciding with a response into a one-entry buffer keeps fetching.
        mode_fullpop = 1'b1;
        for (int i = 0; i < 40 && mode_fullpop; i++) tick();
        chk("fullpop_reached", 32'(mode_fullpop), 32'd0);
        p_ready = 100;
        repeat (6) tick();

        // Redirect to a misaligned target while a request is outstanding.
        max_lat = 3;
        for (int i = 0; i < 40 && !pend; i++) tick();
        chk("redir_outstanding", 32'(pend), 32'd1);
        pend_wait  = 2;
        dir_redir  = 1'b1;
        dir_tgt    = 32'h0000_1003;
        tick();
        cap_pop_en = 1'b1;
        cap_gnt_en = 1'b1;
        repeat (20) tick();
        chk("redir_first_addr", cap_gnt_addr, 32'h0000_1000);
        chk("redir_first_if_pc", cap_pop_pc, 32'h0000_1000);

        // Address wrap at the top of the address space.
        max_lat   = 1;
        dir_redir = 1'b1;
        dir_tgt   = 32'hFFFF_FFF8;
        tick();
        repeat (14) tick();

        // Reset while waiting on memory, then a stray response after release.
        max_lat = 3;
        for (int i = 0; i < 40 && !pend; i++) tick();
        chk("pre_rst_pend", 32'(pend), 32'd1);
        @(negedge clk);
        chk("pre_rst_wait", 32'(dbg_state), 32'(ST_WAIT));
        do_reset(1'b1);
        cap_pop_en = 1'b1;
        p_ready = 100;
        repeat (16) tick();
        chk("post_rst_first_if_pc", cap_pop_pc, RESET_PC);

        // Random traffic with random redirects.
        p_gnt = 70; p_ready = 60; p_redir = 3; max_lat = 3;
        repeat (800) tick();

        // Drain: no new grants, everything fetched must reach decode.
        p_gnt = 0; p_redir = 0; p_ready = 100;
        repeat (10) tick();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_if_valid", 32'(bus.if_valid), 32'd0);
        chk("progress", 32'(n_pops > 150), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
